// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity codes, FSM states, oversampling points.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int unsigned OVS = 16;
  localparam int unsigned MID = 8;

  // Majority samples straddle the bit centre; a bit ends on the last oversample.
  localparam logic [3:0] SC_S7   = 4'(MID - 1);
  localparam logic [3:0] SC_S8   = 4'(MID);
  localparam logic [3:0] SC_VOTE = 4'(MID + 1);
  localparam logic [3:0] SC_LAST = 4'(OVS - 1);

  typedef enum logic [2:0] {
    StOff,
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2,
    StBreakWait
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Code 11 is treated as "no parity", same as 00.
  function automatic logic par_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_receiver_fifo_if.sv
// Pop-side handshake of the receive FIFO: head word, status flags and valid/ready.
interface uart_receiver_fifo_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] Rx_DATA;
  logic              Rx_PERROR;
  logic              Rx_FERROR;
  logic              Rx_BREAK;
  logic              Rx_VALID;
  logic              Rx_OVERRUN;
  logic              Rx_READY;

  modport master (
    output Rx_DATA,
    output Rx_PERROR,
    output Rx_FERROR,
    output Rx_BREAK,
    output Rx_VALID,
    output Rx_OVERRUN,
    input  Rx_READY
  );

  modport slave (
    input  Rx_DATA,
    input  Rx_PERROR,
    input  Rx_FERROR,
    input  Rx_BREAK,
    input  Rx_VALID,
    input  Rx_OVERRUN,
    output Rx_READY
  );
endinterface

// File: rtl/baud_controller.sv
// 16x oversampling tick generator; baud_select picks the clk divisor (64,32,16,8,4,2,1,1).
module baud_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  output logic       tick
);

  logic [6:0] cnt_q, cnt_d;
  logic [6:0] limit;

  // Divisor minus one for the selected rate.
  always_comb begin
    limit = 7'd0;
    unique case (baud_select)
      3'd0:    limit = 7'd63;
      3'd1:    limit = 7'd31;
      3'd2:    limit = 7'd15;
      3'd3:    limit = 7'd7;
      3'd4:    limit = 7'd3;
      3'd5:    limit = 7'd1;
      default: limit = 7'd0;
    endcase
  end

  // >= recovers cleanly if the rate is lowered while the counter is above the new limit.
  assign tick  = (cnt_q >= limit);
  assign cnt_d = tick ? 7'd0 : cnt_q + 7'd1;

  // Divider counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= 7'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; dout shows the head whenever empty is low.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  // Extra MSB on the pointers separates full from empty.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rptr_q[AW-1:0]];

  // Storage array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

  // Read and write pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/uart_receiver_fifo.sv
// UART receiver: synchroniser, 3-sample majority vote, frame FSM with break detection,
// and a FWFT receive FIFO with sticky overrun.
module uart_receiver_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            baud_select,
  input  logic                  Rx_EN,
  input  logic                  RxD,
  input  logic [1:0]            parity_mode,
  input  logic                  stop2,
  uart_receiver_fifo_if.master  rx_if
);

  localparam int unsigned FW = DATA_W + 3;

  logic tick;

  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic s7_q, s8_q, bit_q;
  logic vote, at_vote, at_end, data_par, is_break;

  rx_state_e         state_q, state_d;
  logic [3:0]        sc_q, sc_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        par_mode_q, par_mode_d;
  logic              stop2_q, stop2_d;
  logic              perr_q, perr_d;
  logic              par_bit_q, par_bit_d;

  logic          push, push_brk, push_ferr;
  logic          fifo_full, fifo_empty, pop_fire;
  logic [FW-1:0] fifo_din, fifo_dout;
  logic          ovr_q;

  baud_controller u_baud (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .tick        (tick)
  );

  // Two-flop synchroniser plus a delayed copy for falling-edge detection; line idles high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign vote    = maj3(s7_q, s8_q, rx_sync_q);
  assign at_vote = tick && (sc_q == SC_VOTE);
  assign at_end  = tick && (sc_q == SC_LAST);
  assign data_par = ^data_q;
  assign is_break = !vote && (data_q == '0) && (!par_enabled(par_mode_q) || !par_bit_q);

  // Capture the first two majority samples and hold the voted bit until the bit ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s7_q  <= 1'b0;
      s8_q  <= 1'b0;
      bit_q <= 1'b0;
    end else if (tick) begin
      if (sc_q == SC_S7)   s7_q  <= rx_sync_q;
      if (sc_q == SC_S8)   s8_q  <= rx_sync_q;
      if (sc_q == SC_VOTE) bit_q <= vote;
    end
  end

  // Frame state and per-frame registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StOff;
      sc_q       <= 4'd0;
      bit_cnt_q  <= 4'd0;
      data_q     <= '0;
      par_mode_q <= PAR_NONE;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      par_bit_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sc_q       <= sc_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      perr_q     <= perr_d;
      par_bit_q  <= par_bit_d;
    end
  end

  // Next-state logic and push decision.
  always_comb begin
    state_d    = state_q;
    sc_d       = tick ? sc_q + 4'd1 : sc_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    perr_d     = perr_q;
    par_bit_d  = par_bit_q;
    push       = 1'b0;
    push_brk   = 1'b0;
    push_ferr  = 1'b0;

    unique case (state_q)
      StOff: begin
        sc_d = 4'd0;
        if (Rx_EN) state_d = StIdle;
      end
      StIdle: begin
        sc_d = 4'd0;
        if (rx_prev_q && !rx_sync_q) begin
          state_d    = StStart;
          bit_cnt_d  = 4'd0;
          data_d     = '0;
          par_mode_d = parity_mode;
          stop2_d    = stop2;
          perr_d     = 1'b0;
          par_bit_d  = 1'b0;
        end
      end
      StStart: begin
        if (at_vote && vote) state_d = StIdle;
        else if (at_end)     state_d = StData;
      end
      StData: begin
        if (at_end) begin
          data_d    = {bit_q, data_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(DATA_W - 1)) begin
            state_d = par_enabled(par_mode_q) ? StParity : StStop1;
          end
        end
      end
      StParity: begin
        if (at_end) begin
          par_bit_d = bit_q;
          perr_d    = (par_mode_q == PAR_ODD) ? !(data_par ^ bit_q) : (data_par ^ bit_q);
          state_d   = StStop1;
        end
      end
      StStop1: begin
        if (at_vote) begin
          if (is_break) begin
            push      = 1'b1;
            push_brk  = 1'b1;
            push_ferr = 1'b1;
            state_d   = StBreakWait;
          end else if (stop2_q && vote) begin
            state_d = StStop2;
          end else begin
            push      = 1'b1;
            push_ferr = !vote;
            state_d   = StIdle;
          end
        end
      end
      StStop2: begin
        if (at_vote) begin
          push      = 1'b1;
          push_ferr = !vote;
          state_d   = StIdle;
        end
      end
      StBreakWait: begin
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StOff;
    endcase

    // Disabling abandons any partial frame without a push.
    if (!Rx_EN) begin
      state_d = StOff;
      push    = 1'b0;
    end
  end

  assign fifo_din = {push_brk, push_ferr, perr_q, data_q};
  assign pop_fire = !fifo_empty && rx_if.Rx_READY;

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop_fire),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // Sticky overrun: set on a dropped word, cleared by the next pop; set has priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              ovr_q <= 1'b0;
    else if (push && fifo_full && !pop_fire) ovr_q <= 1'b1;
    else if (pop_fire)                       ovr_q <= 1'b0;
  end

  assign rx_if.Rx_VALID   = !fifo_empty;
  assign rx_if.Rx_DATA    = fifo_dout[DATA_W-1:0];
  assign rx_if.Rx_PERROR  = fifo_dout[DATA_W];
  assign rx_if.Rx_FERROR  = fifo_dout[DATA_W+1];
  assign rx_if.Rx_BREAK   = fifo_dout[DATA_W+2];
  assign rx_if.Rx_OVERRUN = ovr_q;

endmodule

// File: tb/tb_uart_receiver_fifo.sv
// Directed bench for uart_receiver_fifo at baud code 3 (8 clk per tick, 128 clk per bit).
module tb_uart_receiver_fifo;
  import uart_pkg::*;

  localparam int BIT = 128;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] baud_select = 3'd3;
  logic       rx_en = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] parity_mode = 2'b00;
  logic       stop2 = 1'b0;

  int checks = 0;
  int errors = 0;

  uart_receiver_fifo_if #(.DATA_W(8)) rx_if ();

  uart_receiver_fifo #(
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Rx_EN       (rx_en),
    .RxD         (rxd),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .rx_if       (rx_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic line_bit(input logic v);
    rxd = v;
    repeat (BIT) @(negedge clk);
  endtask

  // par < 0 means no parity bit; otherwise par[0] is sent as the parity bit.
  task automatic send_frame(input logic [7:0] d, input int par, input int nstop);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
    if (par >= 0) line_bit(par[0]);
    for (int i = 0; i < nstop; i++) line_bit(1'b1);
  endtask

  task automatic pop_one();
    rx_if.Rx_READY = 1'b1;
    @(negedge clk);
    rx_if.Rx_READY = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] w;
    rx_if.Rx_READY = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_valid",   16'(rx_if.Rx_VALID),   16'h0);
    check("rst_data",    16'(rx_if.Rx_DATA),    16'h0);
    check("rst_perror",  16'(rx_if.Rx_PERROR),  16'h0);
    check("rst_ferror",  16'(rx_if.Rx_FERROR),  16'h0);
    check("rst_break",   16'(rx_if.Rx_BREAK),   16'h0);
    check("rst_overrun", 16'(rx_if.Rx_OVERRUN), 16'h0);
    reset = 1'b1;
    rx_en = 1'b1;
    repeat (2 * BIT) @(negedge clk);

    // 8N1 0xA5, no pop.
    send_frame(8'hA5, -1, 1);
    check("a5_valid",  16'(rx_if.Rx_VALID),  16'h1);
    check("a5_data",   16'(rx_if.Rx_DATA),   16'h00A5);
    check("a5_perror", 16'(rx_if.Rx_PERROR), 16'h0);
    check("a5_ferror", 16'(rx_if.Rx_FERROR), 16'h0);
    check("a5_break",  16'(rx_if.Rx_BREAK),  16'h0);
    pop_one();
    check("a5_popped", 16'(rx_if.Rx_VALID), 16'h0);

    // 8E2 0x3C: even parity bit should be 0, so 1 is an error.
    parity_mode = PAR_EVEN;
    stop2 = 1'b1;
    repeat (BIT) @(negedge clk);
    send_frame(8'h3C, 1, 2);
    check("e2_bad_valid",  16'(rx_if.Rx_VALID),  16'h1);
    check("e2_bad_data",   16'(rx_if.Rx_DATA),   16'h003C);
    check("e2_bad_perror", 16'(rx_if.Rx_PERROR), 16'h1);
    check("e2_bad_ferror", 16'(rx_if.Rx_FERROR), 16'h0);
    pop_one();
    send_frame(8'h3C, 0, 2);
    check("e2_ok_data",   16'(rx_if.Rx_DATA),   16'h003C);
    check("e2_ok_perror", 16'(rx_if.Rx_PERROR), 16'h0);
    pop_one();
    check("e2_empty", 16'(rx_if.Rx_VALID), 16'h0);
    parity_mode = PAR_NONE;
    stop2 = 1'b0;
    repeat (BIT) @(negedge clk);

    // 1.5-sample low glitch is rejected.
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("glitch_valid", 16'(rx_if.Rx_VALID), 16'h0);
    check("glitch_state", 16'(dut.state_q), 16'(StIdle));

    // Break: line low for three frame times.
    rxd = 1'b0;
    repeat (30 * BIT) @(negedge clk);
    check("brk_valid",  16'(rx_if.Rx_VALID),  16'h1);
    check("brk_data",   16'(rx_if.Rx_DATA),   16'h0);
    check("brk_break",  16'(rx_if.Rx_BREAK),  16'h1);
    check("brk_ferror", 16'(rx_if.Rx_FERROR), 16'h1);
    pop_one();
    repeat (2 * BIT) @(negedge clk);
    check("brk_single", 16'(rx_if.Rx_VALID), 16'h0);
    check("brk_wait",   16'(dut.state_q), 16'(StBreakWait));
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("brk_idle",   16'(dut.state_q), 16'(StIdle));
    check("brk_nopush", 16'(rx_if.Rx_VALID), 16'h0);

    // Five frames into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) begin
      w = 8'(i);
      send_frame(w, -1, 1);
    end
    check("ovr_set",   16'(rx_if.Rx_OVERRUN), 16'h1);
    check("ovr_head1", 16'(rx_if.Rx_DATA),    16'h0001);
    pop_one();
    check("ovr_head2", 16'(rx_if.Rx_DATA),    16'h0002);
    check("ovr_clear", 16'(rx_if.Rx_OVERRUN), 16'h0);
    pop_one();
    check("ovr_head3", 16'(rx_if.Rx_DATA), 16'h0003);
    pop_one();
    check("ovr_head4", 16'(rx_if.Rx_DATA), 16'h0004);
    pop_one();
    check("ovr_empty", 16'(rx_if.Rx_VALID), 16'h0);

    // Rx_EN dropped during DATA of 0x55 with 0x11 queued.
    send_frame(8'h11, -1, 1);
    w = 8'h55;
    line_bit(1'b0);
    for (int i = 0; i < 4; i++) line_bit(w[i]);
    rxd = w[4];
    repeat (BIT / 2) @(negedge clk);
    rx_en = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    for (int i = 5; i < 8; i++) line_bit(w[i]);
    line_bit(1'b1);
    check("en_off_state", 16'(dut.state_q), 16'(StOff));
    rx_en = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("en_valid",   16'(rx_if.Rx_VALID),   16'h1);
    check("en_data",    16'(rx_if.Rx_DATA),    16'h0011);
    check("en_overrun", 16'(rx_if.Rx_OVERRUN), 16'h0);
    pop_one();
    check("en_no55", 16'(rx_if.Rx_VALID), 16'h0);

    // Fill and overrun again, then reset clears everything.
    for (int i = 1; i <= 5; i++) begin
      w = 8'(8'h20 + i);
      send_frame(w, -1, 1);
    end
    check("pre_rst_ovr",  16'(rx_if.Rx_OVERRUN), 16'h1);
    check("pre_rst_data", 16'(rx_if.Rx_DATA),    16'h0021);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst2_valid",   16'(rx_if.Rx_VALID),   16'h0);
    check("rst2_data",    16'(rx_if.Rx_DATA),    16'h0);
    check("rst2_overrun", 16'(rx_if.Rx_OVERRUN), 16'h0);
    check("rst2_state",   16'(dut.state_q),      16'(StOff));
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
